// File: rtl/axi4_wr_arbiter_if.sv
// Requester-side (s_*) and downstream (m_*) AXI4 write channels of the write arbiter.
// master modport is the arbiter's view; slave is the view of the requesters plus downstream port.
interface axi4_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 512,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4
);
  logic [NUM_REQ*IDWIDTH-1:0]  s_awid;
  logic [NUM_REQ*AWIDTH-1:0]   s_awaddr;
  logic [NUM_REQ*8-1:0]        s_awlen;
  logic [NUM_REQ*3-1:0]        s_awsize;
  logic [NUM_REQ*2-1:0]        s_awburst;
  logic [NUM_REQ-1:0]          s_awvalid;
  logic [NUM_REQ-1:0]          s_awready;
  logic [NUM_REQ*DWIDTH-1:0]   s_wdata;
  logic [NUM_REQ*DWIDTH/8-1:0] s_wstrb;
  logic [NUM_REQ-1:0]          s_wlast;
  logic [NUM_REQ-1:0]          s_wvalid;
  logic [NUM_REQ-1:0]          s_wready;
  logic [1:0]                  s_bresp;
  logic [NUM_REQ-1:0]          s_bvalid;
  logic [NUM_REQ-1:0]          s_bready;

  logic [IDWIDTH-1:0]          m_awid;
  logic [AWIDTH-1:0]           m_awaddr;
  logic [7:0]                  m_awlen;
  logic [2:0]                  m_awsize;
  logic [1:0]                  m_awburst;
  logic                        m_awvalid;
  logic                        m_awready;
  logic [DWIDTH-1:0]           m_wdata;
  logic [DWIDTH/8-1:0]         m_wstrb;
  logic                        m_wlast;
  logic                        m_wvalid;
  logic                        m_wready;
  logic [1:0]                  m_bresp;
  logic                        m_bvalid;
  logic                        m_bready;

  modport master (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bresp, s_bvalid,
    input  s_bready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bvalid,
    output s_bready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Round-robin share of one AXI4 write port among NUM_REQ requesters, one burst in flight.
// Latency: grant 1 cycle after a request seen in IDLE; AW/W/B pass through combinationally.
// Backpressure: downstream ready/valid reaches only the granted requester; others see 0.
module axi4_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DWIDTH  = 512,
  parameter int AWIDTH  = 32,
  parameter int IDWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  axi4_wr_arbiter_if.master   axi,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                err_last
);
  localparam int          IW = $clog2(NUM_REQ);
  localparam int          SW = DWIDTH / 8;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] rr_ptr, gnt_idx, pick_idx;
  logic          pick_vld;
  logic [7:0]    len_q, beat_cnt;
  logic          last_beat, aw_hs, w_hs, b_hs;

  logic [IDWIDTH-1:0] awid_a    [NUM_REQ];
  logic [AWIDTH-1:0]  awaddr_a  [NUM_REQ];
  logic [7:0]         awlen_a   [NUM_REQ];
  logic [2:0]         awsize_a  [NUM_REQ];
  logic [1:0]         awburst_a [NUM_REQ];
  logic [DWIDTH-1:0]  wdata_a   [NUM_REQ];
  logic [SW-1:0]      wstrb_a   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign awid_a[i]    = axi.s_awid[i*IDWIDTH +: IDWIDTH];
    assign awaddr_a[i]  = axi.s_awaddr[i*AWIDTH +: AWIDTH];
    assign awlen_a[i]   = axi.s_awlen[i*8 +: 8];
    assign awsize_a[i]  = axi.s_awsize[i*3 +: 3];
    assign awburst_a[i] = axi.s_awburst[i*2 +: 2];
    assign wdata_a[i]   = axi.s_wdata[i*DWIDTH +: DWIDTH];
    assign wstrb_a[i]   = axi.s_wstrb[i*SW +: SW];
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NR) s = s - NR;
    return s[IW-1:0];
  endfunction

  // First requesting index at or after rr_ptr, scanning upward with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!pick_vld && axi.s_awvalid[wrap_inc(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_inc(rr_ptr, k);
      end
    end
  end

  assign last_beat = (beat_cnt == len_q);
  assign aw_hs     = (state == ADDR) && axi.s_awvalid[gnt_idx] && axi.m_awready;
  assign w_hs      = (state == DATA) && axi.s_wvalid[gnt_idx] && axi.m_wready;
  assign b_hs      = (state == RESP) && axi.m_bvalid && axi.s_bready[gnt_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    axi.m_awid    = awid_a[gnt_idx];
    axi.m_awaddr  = awaddr_a[gnt_idx];
    axi.m_awlen   = awlen_a[gnt_idx];
    axi.m_awsize  = awsize_a[gnt_idx];
    axi.m_awburst = awburst_a[gnt_idx];
    axi.m_awvalid = 1'b0;
    axi.s_awready = '0;
    axi.m_wdata   = wdata_a[gnt_idx];
    axi.m_wstrb   = wstrb_a[gnt_idx];
    axi.m_wlast   = 1'b0;
    axi.m_wvalid  = 1'b0;
    axi.s_wready  = '0;
    axi.s_bresp   = axi.m_bresp;
    axi.s_bvalid  = '0;
    axi.m_bready  = 1'b0;
    case (state)
      IDLE: if (pick_vld) state_nxt = ADDR;
      ADDR: begin
        axi.m_awvalid          = axi.s_awvalid[gnt_idx];
        axi.s_awready[gnt_idx] = axi.m_awready;
        if (aw_hs) state_nxt = DATA;
      end
      DATA: begin
        axi.m_wlast           = last_beat;
        axi.m_wvalid          = axi.s_wvalid[gnt_idx];
        axi.s_wready[gnt_idx] = axi.m_wready;
        if (w_hs && last_beat) state_nxt = RESP;
      end
      RESP: begin
        axi.s_bvalid[gnt_idx] = axi.m_bvalid;
        axi.m_bready          = axi.s_bready[gnt_idx];
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      gnt      <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_last <= 1'b0;
    end else begin
      // The burst length comes from len_q; s_wlast is only cross-checked.
      err_last <= w_hs && (axi.s_wlast[gnt_idx] != last_beat);
      case (state)
        IDLE: if (pick_vld) begin
          gnt_idx <= pick_idx;
          gnt     <= NUM_REQ'(1) << pick_idx;
          len_q   <= awlen_a[pick_idx];
        end
        ADDR: if (aw_hs) beat_cnt <= '0;
        DATA: if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        RESP: if (b_hs) begin
          rr_ptr <= wrap_inc(gnt_idx, 1);
          gnt    <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Randomized bench for axi4_wr_arbiter: requester/downstream BFMs, round-robin order model, beat scoreboard.
module tb_axi4_wr_arbiter;
  localparam int N = 4, DW = 64, AW = 32, IDW = 4, SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] gnt;
  logic err_last;

  axi4_wr_arbiter_if #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IDW)) bus ();
  axi4_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW), .IDWIDTH(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .axi(bus), .gnt(gnt), .err_last(err_last));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; } beat_t;
  typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic last; int who; } wobs_t;
  typedef struct { int who; logic [AW-1:0] addr; logic [7:0] len; logic [IDW-1:0] id; int cyc; } awobs_t;
  typedef struct { logic [N-1:0] vec; logic [1:0] resp; int cyc; } bobs_t;

  bit              req_pend [N];
  logic [AW-1:0]   r_addr [N];
  logic [7:0]      r_len [N];
  logic [IDW-1:0]  r_id [N];
  int              wsent [N];
  int              wl_beat [N];
  beat_t           wq [N][$];
  beat_t           eq [N][$];
  int              p_aw, p_w, p_b, p_sb;
  logic [1:0]      bresp_val;
  bit              bpend, bv_hold;
  awobs_t          aw_log [$];
  wobs_t           w_log [$];
  bobs_t           b_log [$];
  int              err_log [$];
  int              exp_order [$];
  int              viol, cyc, mdl_ptr;
  int              checks = 0, failures = 0;

  // One clock: drive requesters and downstream slave, then record handshakes.
  task automatic step();
    int who;
    @(posedge clk); #1;
    if (err_last) err_log.push_back(w_log.size());
    for (int r = 0; r < N; r++) begin
      bus.s_awvalid[r]            = req_pend[r];
      bus.s_awid[r*IDW +: IDW]    = r_id[r];
      bus.s_awaddr[r*AW +: AW]    = r_addr[r];
      bus.s_awlen[r*8 +: 8]       = r_len[r];
      bus.s_awsize[r*3 +: 3]      = 3'd3;
      bus.s_awburst[r*2 +: 2]     = 2'b01;
      bus.s_wvalid[r]             = (wq[r].size() > 0);
      if (wq[r].size() > 0) begin
        bus.s_wdata[r*DW +: DW]   = wq[r][0].d;
        bus.s_wstrb[r*SW +: SW]   = wq[r][0].s;
      end
      bus.s_wlast[r]              = (wsent[r] == wl_beat[r]);
      bus.s_bready[r]             = ($urandom_range(99) < p_sb);
    end
    bus.m_awready = ($urandom_range(99) < p_aw);
    bus.m_wready  = ($urandom_range(99) < p_w);
    if (bpend && !bv_hold) bv_hold = ($urandom_range(99) < p_b);
    bus.m_bvalid  = bv_hold;
    bus.m_bresp   = bresp_val;
    #1;
    who = -1;
    for (int r = 0; r < N; r++) if (gnt[r]) who = r;
    if (!$onehot0(gnt)) viol++;
    if (((bus.s_awready | bus.s_wready | bus.s_bvalid) & ~gnt) != '0) viol++;
    if (bus.m_awvalid && bus.s_wready != '0) viol++;
    if (bus.m_awvalid && bus.m_awready)
      aw_log.push_back('{who, bus.m_awaddr, bus.m_awlen, bus.m_awid, cyc});
    if (bus.m_wvalid && bus.m_wready) begin
      w_log.push_back('{bus.m_wdata, bus.m_wstrb, bus.m_wlast, who});
      if (bus.m_wlast) bpend = 1'b1;
    end
    if (bus.m_bvalid && bus.m_bready) begin
      b_log.push_back('{bus.s_bvalid, bus.s_bresp, cyc});
      bpend = 1'b0;
      bv_hold = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      if (bus.s_awvalid[r] && bus.s_awready[r]) req_pend[r] = 1'b0;
      if (bus.s_wvalid[r] && bus.s_wready[r]) begin
        void'(wq[r].pop_front());
        wsent[r]++;
      end
    end
    cyc++;
  endtask

  task automatic post_req(input int r, input int len);
    beat_t bt;
    req_pend[r] = 1'b1;
    r_len[r]    = 8'(len);
    r_addr[r]   = $urandom;
    r_id[r]     = IDW'($urandom_range(15));
    wsent[r]    = 0;
    wl_beat[r]  = len;
    for (int b = 0; b <= len; b++) begin
      bt.d = {$urandom, $urandom};
      bt.s = SW'($urandom);
      wq[r].push_back(bt);
      eq[r].push_back(bt);
    end
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); b_log.delete(); err_log.delete();
    viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) begin
      req_pend[r] = 1'b0; wq[r].delete(); eq[r].delete();
      wsent[r] = 0; wl_beat[r] = -1; r_len[r] = '0; r_addr[r] = '0; r_id[r] = '0;
    end
    p_aw = 100; p_w = 100; p_b = 100; p_sb = 100;
    bresp_val = 2'b00; bpend = 1'b0; bv_hold = 1'b0; mdl_ptr = 0;
    repeat (3) step();
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic run_until(input int nb, input int budget, output bit timed_out);
    int n = 0;
    while (b_log.size() < nb && n < budget) begin
      step();
      n++;
    end
    timed_out = (b_log.size() < nb);
  endtask

  // Round-robin reference: requesters pending together are served once each,
  // in circular index order starting at the pointer; pointer ends one past the last.
  task automatic model_round(input logic [N-1:0] mask);
    exp_order.delete();
    for (int k = 0; k < N; k++)
      if (mask[(mdl_ptr + k) % N]) exp_order.push_back((mdl_ptr + k) % N);
    if (exp_order.size() > 0) mdl_ptr = (exp_order[$] + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    post_req(1, 0);
    step(); step();
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    checks++; if (bus.m_awvalid !== 1'b0 || bus.s_awready !== '0) begin failures++;
      $display("FAIL reset_aw m_awvalid=%b s_awready=%b want 0", bus.m_awvalid, bus.s_awready); end
    checks++; if (bus.m_wvalid !== 1'b0 || bus.s_wready !== '0) begin failures++;
      $display("FAIL reset_w m_wvalid=%b s_wready=%b want 0", bus.m_wvalid, bus.s_wready); end
    checks++; if (bus.m_bready !== 1'b0 || bus.s_bvalid !== '0) begin failures++;
      $display("FAIL reset_b m_bready=%b s_bvalid=%b want 0", bus.m_bready, bus.s_bvalid); end
    checks++; if (err_last !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_last); end
  endtask

  task automatic test_single();
    bit to; int rc;
    do_reset();
    post_req(0, 3);
    rc = cyc;
    run_until(1, 100, to);
    step();
    checks++; if (to) begin failures++; $display("FAIL single_timeout b handshakes=%0d want=1", b_log.size()); end
    checks++; if (aw_log.size() != 1) begin failures++; $display("FAIL single_aw_count got=%0d want=1", aw_log.size()); end
    if (aw_log.size() > 0) begin
      checks++; if (aw_log[0].cyc != rc + 1) begin failures++;
        $display("FAIL single_aw_latency got=%0d want=%0d", aw_log[0].cyc - rc, 1); end
      checks++; if (aw_log[0].who != 0 || aw_log[0].addr !== r_addr[0] || aw_log[0].len !== 8'd3 || aw_log[0].id !== r_id[0]) begin
        failures++; $display("FAIL single_aw_fields who=%0d addr=%h len=%0d id=%0d want 0/%h/3/%0d",
          aw_log[0].who, aw_log[0].addr, aw_log[0].len, aw_log[0].id, r_addr[0], r_id[0]); end
    end
    checks++; if (w_log.size() != 4) begin failures++; $display("FAIL single_w_count got=%0d want=4", w_log.size()); end
    for (int b = 0; b < 4 && b < w_log.size(); b++) begin
      checks++;
      if (w_log[b].d !== eq[0][b].d || w_log[b].s !== eq[0][b].s || w_log[b].last !== (b == 3)) begin
        failures++; $display("FAIL single_beat%0d got=%h/%h/%b want=%h/%h/%b", b, w_log[b].d, w_log[b].s,
          w_log[b].last, eq[0][b].d, eq[0][b].s, b == 3); end
    end
    if (b_log.size() > 0) begin
      checks++; if (b_log[0].vec !== 4'b0001 || b_log[0].resp !== 2'b00) begin failures++;
        $display("FAIL single_b got vec=%b resp=%b want 0001/00", b_log[0].vec, b_log[0].resp); end
    end
    checks++; if (gnt !== '0) begin failures++; $display("FAIL single_gnt_idle got=%b want=0", gnt); end
    checks++; if (viol != 0 || err_log.size() != 0) begin failures++;
      $display("FAIL single_protocol violations=%0d err_pulses=%0d want 0/0", viol, err_log.size()); end
  endtask

  task automatic test_rr();
    bit to; logic [N-1:0] mask; int nbad; int bi;
    do_reset();
    for (int rnd = 0; rnd < 4; rnd++) begin
      clear_logs();
      mask = (rnd == 0) ? 4'b1111 : (rnd == 1) ? 4'b0001 : N'($urandom_range(1, 15));
      for (int r = 0; r < N; r++) if (mask[r]) post_req(r, (rnd == 0) ? 0 : $urandom_range(3));
      model_round(mask);
      run_until(exp_order.size(), 400, to);
      checks++; if (to || aw_log.size() != exp_order.size()) begin failures++;
        $display("FAIL rr%0d_count aw=%0d b=%0d want=%0d", rnd, aw_log.size(), b_log.size(), exp_order.size()); end
      for (int k = 0; k < exp_order.size() && k < aw_log.size(); k++) begin
        checks++; if (aw_log[k].who != exp_order[k] || aw_log[k].len !== r_len[exp_order[k]]) begin failures++;
          $display("FAIL rr%0d_grant%0d got=%0d len=%0d want=%0d len=%0d", rnd, k, aw_log[k].who, aw_log[k].len,
            exp_order[k], r_len[exp_order[k]]); end
        if (k > 0 && k - 1 < b_log.size()) begin
          checks++; if (aw_log[k].cyc - b_log[k-1].cyc < 2) begin failures++;
            $display("FAIL rr%0d_gap%0d got=%0d want>=2", rnd, k, aw_log[k].cyc - b_log[k-1].cyc); end
        end
      end
      nbad = 0; bi = 0;
      foreach (exp_order[k]) begin
        for (int i = 0; i < eq[exp_order[k]].size(); i++) begin
          if (bi >= w_log.size() || w_log[bi].d !== eq[exp_order[k]][i].d || w_log[bi].who != exp_order[k] ||
              w_log[bi].last !== (i == eq[exp_order[k]].size() - 1)) nbad++;
          bi++;
        end
      end
      checks++; if (nbad != 0 || bi != w_log.size()) begin failures++;
        $display("FAIL rr%0d_data bad_beats=%0d beats=%0d want 0/%0d", rnd, nbad, w_log.size(), bi); end
      checks++; if (viol != 0) begin failures++; $display("FAIL rr%0d_protocol violations=%0d want=0", rnd, viol); end
      for (int r = 0; r < N; r++) eq[r].delete();
    end
  endtask

  task automatic test_stall();
    bit to; int nbad;
    do_reset();
    p_aw = 40; p_w = 50; p_b = 40; p_sb = 60; bresp_val = 2'b10;
    post_req(2, 7);
    run_until(1, 600, to);
    checks++; if (to || aw_log.size() != 1 || aw_log[0].who != 2) begin failures++;
      $display("FAIL stall_aw timeout=%b aw=%0d want grant to 2", to, aw_log.size()); end
    checks++; if (w_log.size() != 8) begin failures++; $display("FAIL stall_w_count got=%0d want=8", w_log.size()); end
    nbad = 0;
    for (int b = 0; b < w_log.size() && b < 8; b++)
      if (w_log[b].d !== eq[2][b].d || w_log[b].s !== eq[2][b].s || w_log[b].who != 2 || w_log[b].last !== (b == 7)) nbad++;
    checks++; if (nbad != 0) begin failures++; $display("FAIL stall_data bad_beats=%0d want=0", nbad); end
    if (b_log.size() > 0) begin
      checks++; if (b_log[0].vec !== 4'b0100 || b_log[0].resp !== 2'b10) begin failures++;
        $display("FAIL stall_b got vec=%b resp=%b want 0100/10", b_log[0].vec, b_log[0].resp); end
    end
    checks++; if (viol != 0 || err_log.size() != 0) begin failures++;
      $display("FAIL stall_protocol violations=%0d err_pulses=%0d want 0/0", viol, err_log.size()); end
  endtask

  task automatic test_wlast_err();
    bit to;
    do_reset();
    post_req(1, 2);
    wl_beat[1] = 1;
    run_until(1, 100, to);
    step();
    checks++; if (to || w_log.size() != 3) begin failures++;
      $display("FAIL wlast_burst timeout=%b beats=%0d want 3", to, w_log.size()); end
    checks++; if (err_log.size() != 2) begin failures++; $display("FAIL wlast_err_count got=%0d want=2", err_log.size()); end
    if (err_log.size() == 2) begin
      checks++; if (err_log[0] != 2 || err_log[1] != 3) begin failures++;
        $display("FAIL wlast_err_beats got=%0d,%0d want=2,3", err_log[0], err_log[1]); end
    end
    if (w_log.size() == 3) begin
      checks++; if (w_log[1].last !== 1'b0 || w_log[2].last !== 1'b1) begin failures++;
        $display("FAIL wlast_mlast got beat2=%b beat3=%b want 0/1", w_log[1].last, w_log[2].last); end
    end
  endtask

  task automatic test_long();
    bit to; int nbad, nlast;
    do_reset();
    p_w = 80;
    post_req(3, 255);
    run_until(1, 1500, to);
    step();
    checks++; if (to || w_log.size() != 256) begin failures++;
      $display("FAIL long_count timeout=%b beats=%0d want 256", to, w_log.size()); end
    nbad = 0; nlast = 0;
    for (int b = 0; b < w_log.size() && b < 256; b++) begin
      if (w_log[b].d !== eq[3][b].d || w_log[b].s !== eq[3][b].s) nbad++;
      if (w_log[b].last) nlast++;
    end
    checks++; if (nbad != 0) begin failures++; $display("FAIL long_data bad_beats=%0d want=0", nbad); end
    checks++; if (nlast != 1 || w_log.size() < 256 || w_log[w_log.size()-1].last !== 1'b1) begin failures++;
      $display("FAIL long_wlast count=%0d want 1 on beat 256", nlast); end
    checks++; if (gnt !== '0 || bus.m_awvalid !== 1'b0) begin failures++;
      $display("FAIL long_idle gnt=%b m_awvalid=%b want 0/0", gnt, bus.m_awvalid); end
  endtask

  task automatic test_reset_mid();
    bit to; int n = 0;
    do_reset();
    post_req(0, 7);
    while (w_log.size() < 3 && n < 50) begin step(); n++; end
    checks++; if (w_log.size() < 3) begin failures++; $display("FAIL midrst_reach beats=%0d want>=3", w_log.size()); end
    rst_n = 1'b0;
    step();
    checks++; if (gnt !== '0 || bus.m_awvalid !== 1'b0 || bus.m_wvalid !== 1'b0 || bus.m_bready !== 1'b0) begin
      failures++; $display("FAIL midrst_master gnt=%b awv=%b wv=%b bready=%b want 0", gnt, bus.m_awvalid,
        bus.m_wvalid, bus.m_bready); end
    checks++; if (bus.s_awready !== '0 || bus.s_wready !== '0 || bus.s_bvalid !== '0) begin failures++;
      $display("FAIL midrst_req awready=%b wready=%b bvalid=%b want 0", bus.s_awready, bus.s_wready, bus.s_bvalid); end
    do_reset();
    post_req(3, 1);
    run_until(1, 60, to);
    checks++; if (to || aw_log.size() != 1 || aw_log[0].who != 3 || w_log.size() != 2) begin failures++;
      $display("FAIL midrst_regrant timeout=%b aw=%0d beats=%0d want grant 3 with 2 beats", to, aw_log.size(), w_log.size()); end
  endtask

  initial begin
    bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0; bus.s_awburst = '0;
    bus.s_awvalid = '0; bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = '0; bus.s_wvalid = '0;
    bus.s_bready = '0; bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bresp = 2'b00; bus.m_bvalid = 1'b0;
    cyc = 0; viol = 0;
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_wlast_err();
    test_long();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
